// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// A writeback request is a destination register plus its result data.
package rf_wb_pkg;

    localparam int XLEN           = 32;
    localparam int AW             = 5;
    localparam int STARVE_MAX_DEF = 4;
    localparam int FIFO_DEPTH_DEF = 2;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small wb_req_t FIFO for buffered LSU results, with full/empty/count and an
// age-ordered entry view (index 0 = head/oldest) for the bypass lookup.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_i,
    input  wb_req_t              enq_req_i,
    input  logic                 deq_i,
    output wb_req_t              head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CW-1:0]        count_o,
    output wb_req_t [DEPTH-1:0]  ent_o,
    output logic [DEPTH-1:0]     ent_vld_o
);

    wb_req_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_enq;
    logic          do_deq;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_enq = enq_i && !full_o;
    assign do_deq = deq_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_enq) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_deq) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_enq, do_deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem_q[wr_ptr_q] <= enq_req_i;
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_o[k]     = mem_q[rd_ptr_q + PW'(k)];
            ent_vld_o[k] = (CW'(k) < count_q);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: ALU results win over buffered LSU results,
// with a starvation counter forcing the LSU through. Optional RF_BYPASS_EN.
module rf_write_arbiter
    import rf_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_stall,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            lsu_pending,
    input  logic [AW-1:0]   byp_rs1,
    input  logic [AW-1:0]   byp_rs2,
    output logic            byp_hit1,
    output logic            byp_hit2,
    output logic [XLEN-1:0] byp_data1,
    output logic [XLEN-1:0] byp_data2
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    wb_req_t                  lsu_req;
    wb_req_t                  alu_req;
    wb_req_t                  fifo_head;
    wb_req_t [FIFO_DEPTH-1:0] fifo_ent;
    logic [FIFO_DEPTH-1:0]    fifo_ent_vld;
    logic [CW-1:0]            fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_deq;

    logic                     force_lsu;
    logic                     win_valid;
    wb_req_t                  win_req;
    logic [SW-1:0]            starve_q;
    logic [SW-1:0]            starve_d;

    logic                     rf_we_q;
    logic [AW-1:0]            rf_waddr_q;
    logic [XLEN-1:0]          rf_wdata_q;

    assign lsu_req = '{rd: lsu_rd, data: lsu_data};
    assign alu_req = '{rd: alu_rd, data: alu_data};

    // Every LSU result goes through the FIFO, even when it is empty.
    rf_wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .enq_i     (lsu_valid),
        .enq_req_i (lsu_req),
        .deq_i     (fifo_deq),
        .head_o    (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count),
        .ent_o     (fifo_ent),
        .ent_vld_o (fifo_ent_vld)
    );

    // Ready comes only from the registered occupancy, never from a same-cycle dequeue.
    assign lsu_ready   = !fifo_full;
    assign lsu_pending = !fifo_empty;

    assign force_lsu = !fifo_empty && (starve_q == SW'(STARVE_MAX));
    assign alu_stall = force_lsu && alu_valid;

    always_comb begin
        win_valid = 1'b0;
        win_req   = alu_req;
        fifo_deq  = 1'b0;
        starve_d  = '0;
        if (force_lsu) begin
            win_valid = 1'b1;
            win_req   = fifo_head;
            fifo_deq  = 1'b1;
        end else if (alu_valid) begin
            win_valid = 1'b1;
            win_req   = alu_req;
            if (!fifo_empty) begin
                starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
            end
        end else if (!fifo_empty) begin
            win_valid = 1'b1;
            win_req   = fifo_head;
            fifo_deq  = 1'b1;
        end
    end

    // A winner with rd == 0 is consumed but never raises the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            rf_we_q  <= win_valid && (win_req.rd != '0);
            if (win_valid) begin
                rf_waddr_q <= win_req.rd;
                rf_wdata_q <= win_req.data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    logic unused_cnt;
    assign unused_cnt = ^fifo_count;

`ifdef RF_BYPASS_EN
    // Later FIFO entries are younger, so scanning head-to-tail leaves the youngest match.
    function automatic logic [XLEN:0] byp_lookup(input logic [AW-1:0] rs);
        logic            hit;
        logic [XLEN-1:0] data;
        hit  = 1'b0;
        data = '0;
        if (rs != '0) begin
            if (rf_we_q && (rf_waddr_q == rs)) begin
                hit  = 1'b1;
                data = rf_wdata_q;
            end
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (fifo_ent_vld[k] && (fifo_ent[k].rd == rs)) begin
                    hit  = 1'b1;
                    data = fifo_ent[k].data;
                end
            end
        end
        return {hit, data};
    endfunction

    assign {byp_hit1, byp_data1} = byp_lookup(byp_rs1);
    assign {byp_hit2, byp_data2} = byp_lookup(byp_rs2);
`else
    logic unused_byp;
    assign unused_byp = ^{fifo_ent, fifo_ent_vld, byp_rs1, byp_rs2};

    assign byp_hit1  = 1'b0;
    assign byp_hit2  = 1'b0;
    assign byp_data1 = '0;
    assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: random and directed traffic checked against a
// queue-based reference of the arbitration rules; a monitor pops expected writes.
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        lsu_pending;
    logic [4:0]  byp_rs1;
    logic [4:0]  byp_rs2;
    logic        byp_hit1;
    logic        byp_hit2;
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;

    rf_write_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_stall   (alu_stall),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .lsu_pending (lsu_pending),
        .byp_rs1     (byp_rs1),
        .byp_rs2     (byp_rs2),
        .byp_hit1    (byp_hit1),
        .byp_hit2    (byp_hit2),
        .byp_data1   (byp_data1),
        .byp_data2   (byp_data2)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // scoreboard: expected register-file writes as {rd, data}
    logic [36:0] exp_q[$];

    // reference model state
    logic [36:0] m_lsu_q[$];
    int          m_starve;
    logic        m_st_we;
    logic [4:0]  m_st_rd;
    logic [31:0] m_st_data;
    logic        m_stall;
    logic        m_ready;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_lsu_q.delete();
        exp_q.delete();
        m_starve  = 0;
        m_st_we   = 1'b0;
        m_st_rd   = '0;
        m_st_data = '0;
        m_stall   = 1'b0;
        m_ready   = 1'b1;
    endtask

`ifdef RF_BYPASS_EN
    function automatic logic [32:0] byp_expect(input logic [4:0] rs);
        if (rs == 5'd0) return 33'd0;
        for (int k = m_lsu_q.size() - 1; k >= 0; k--) begin
            if (m_lsu_q[k][36:32] == rs) return {1'b1, m_lsu_q[k][31:0]};
        end
        if (m_st_we && (m_st_rd == rs)) return {1'b1, m_st_data};
        return 33'd0;
    endfunction
`endif

    // monitor: every write the DUT presents must be the next expected one
    always @(negedge clk) begin : monitor
        logic [36:0] e;
        if (!rst && rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write at %0t",
                         rf_waddr, rf_wdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e[36:32]});
                check("rf_wdata", rf_wdata, e[31:0]);
            end
        end
    end

    // driver: one clock cycle with the inputs currently driven
    task automatic cycle();
        logic [36:0] w;
        logic        win;
        logic [32:0] eb1;
        logic [32:0] eb2;
        @(negedge clk);
        #1;
        m_stall = (m_lsu_q.size() > 0) && (m_starve == SMAX) && alu_valid;
        m_ready = (m_lsu_q.size() < DEPTH);
        check("alu_stall", {31'd0, alu_stall}, {31'd0, m_stall});
        check("lsu_ready", {31'd0, lsu_ready}, {31'd0, m_ready});
        check("lsu_pending", {31'd0, lsu_pending}, (m_lsu_q.size() > 0) ? 32'd1 : 32'd0);
`ifdef RF_BYPASS_EN
        eb1 = byp_expect(byp_rs1);
        eb2 = byp_expect(byp_rs2);
`else
        eb1 = 33'd0;
        eb2 = 33'd0;
`endif
        check("byp_hit1", {31'd0, byp_hit1}, {31'd0, eb1[32]});
        check("byp_data1", byp_data1, eb1[31:0]);
        check("byp_hit2", {31'd0, byp_hit2}, {31'd0, eb2[32]});
        check("byp_data2", byp_data2, eb2[31:0]);

        win = 1'b0;
        w   = '0;
        if (m_lsu_q.size() > 0 && m_starve == SMAX) begin
            w = m_lsu_q.pop_front();
            win = 1'b1;
            m_starve = 0;
        end else if (alu_valid) begin
            w = {alu_rd, alu_data};
            win = 1'b1;
            m_starve = (m_lsu_q.size() > 0) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        end else if (m_lsu_q.size() > 0) begin
            w = m_lsu_q.pop_front();
            win = 1'b1;
            m_starve = 0;
        end else begin
            m_starve = 0;
        end
        if (lsu_valid && m_ready) m_lsu_q.push_back({lsu_rd, lsu_data});
        m_st_we = win && (w[36:32] != 5'd0);
        if (win) begin
            m_st_rd   = w[36:32];
            m_st_data = w[31:0];
        end
        if (m_st_we) exp_q.push_back(w);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        check({tag, "_rf_waddr"}, {27'd0, rf_waddr}, 32'd0);
        check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
        check({tag, "_alu_stall"}, {31'd0, alu_stall}, 32'd0);
        check({tag, "_lsu_ready"}, {31'd0, lsu_ready}, 32'd1);
        check({tag, "_lsu_pending"}, {31'd0, lsu_pending}, 32'd0);
        check({tag, "_byp_hit1"}, {31'd0, byp_hit1}, 32'd0);
        check({tag, "_byp_data1"}, byp_data1, 32'd0);
    endtask

    initial begin
        int stalls;
        int stall_at;
        int n_lsu;
        int ready_low;
        logic alu_hold;
        logic lsu_hold;

        rst = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        byp_rs1 = '0; byp_rs2 = '0;
        model_reset();
        #1;
        check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234_5678;
        cycle();
        check("alu_only_we", {31'd0, rf_we}, 32'd1);
        check("alu_only_waddr", {27'd0, rf_waddr}, 32'd3);
        check("alu_only_wdata", rf_wdata, 32'h1234_5678);
        idle(2);

        // LSU only: two-cycle latency through the empty FIFO
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEAD_BEEF;
        cycle();
        lsu_valid = 1'b0;
        check("lsu_lat1_we", {31'd0, rf_we}, 32'd0);
        cycle();
        check("lsu_lat2_we", {31'd0, rf_we}, 32'd1);
        check("lsu_lat2_waddr", {27'd0, rf_waddr}, 32'd7);
        check("lsu_lat2_wdata", rf_wdata, 32'hDEAD_BEEF);
        idle(2);

        // starvation: one LSU entry behind continuous ALU traffic
        stalls = 0; stall_at = -1;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA000_0000;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0099;
        for (int i = 0; i < 10; i++) begin
            cycle();
            lsu_valid = 1'b0;
            if (m_stall) begin
                stalls++;
                stall_at = i;
            end else begin
                alu_rd = alu_rd + 5'd1;
                alu_data = alu_data + 32'd1;
            end
        end
        check("starve_stall_count", stalls, 32'd1);
        check("starve_stall_cycle", stall_at, 32'd5);
        idle(3);

        // full FIFO: three back-to-back offers with continuous ALU traffic
        n_lsu = 0; ready_low = 0;
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hB000_0000;
        for (int i = 0; i < 20; i++) begin
            lsu_valid = (n_lsu < 3);
            lsu_rd = 5'd11 + n_lsu[4:0];
            lsu_data = 32'hC000_0000 + n_lsu;
            cycle();
            if (lsu_valid && m_ready) n_lsu++;
            if (!m_ready) ready_low++;
            if (!m_stall) begin
                alu_rd = (alu_rd == 5'd30) ? 5'd20 : alu_rd + 5'd1;
                alu_data = alu_data + 32'd1;
            end
        end
        check("full_ready_low_seen", (ready_low > 0) ? 32'd1 : 32'd0, 32'd1);
        check("full_all_accepted", n_lsu, 32'd3);
        idle(5);

        // rd == 0 on both streams is consumed without a write
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555_5555;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h6666_6666;
        cycle();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        check("rd0_alu_we", {31'd0, rf_we}, 32'd0);
        cycle();
        check("rd0_lsu_we", {31'd0, rf_we}, 32'd0);
        idle(2);

        // two FIFO entries for rd=5 held behind ALU traffic
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h7000_0000;
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'h1;
        byp_rs1 = 5'd5; byp_rs2 = 5'd0;
        cycle();
        lsu_data = 32'h2; alu_data = 32'h7000_0001;
        cycle();
        lsu_valid = 1'b0;
`ifdef RF_BYPASS_EN
        check("byp_youngest_hit", {31'd0, byp_hit1}, 32'd1);
        check("byp_youngest_data", byp_data1, 32'h2);
`else
        check("byp_off_hit", {31'd0, byp_hit1}, 32'd0);
        check("byp_off_data", byp_data1, 32'd0);
`endif
        check("byp_rs0_hit", {31'd0, byp_hit2}, 32'd0);
        alu_data = 32'h7000_0002;
        cycle();
        idle(4);

        // reset with one entry buffered
        lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h2020_2020;
        cycle();
        lsu_valid = 1'b0;
        check("rst_pre_pending", {31'd0, lsu_pending}, 32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("mid_rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        cycle();
        check("post_rst_we1", {31'd0, rf_we}, 32'd0);
        cycle();
        check("post_rst_we2", {31'd0, rf_we}, 32'd0);

        // random traffic with valid held until accepted
        alu_hold = 1'b0; lsu_hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!alu_hold) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd = 5'($urandom_range(0, 31));
                alu_data = $urandom;
            end
            if (!lsu_hold) begin
                lsu_valid = ($urandom_range(0, 99) < 45);
                lsu_rd = 5'($urandom_range(0, 7));
                lsu_data = $urandom;
            end
            byp_rs1 = 5'($urandom_range(0, 7));
            byp_rs2 = 5'($urandom_range(0, 31));
            cycle();
            alu_hold = alu_valid && m_stall;
            lsu_hold = lsu_valid && !m_ready;
        end
        idle(6);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
